// File: rtl/ids_dma_pkg.sv
`default_nettype none
// ================================================================
// ids_dma_pkg : state type and bus constants for ids_dma_ctrl
// Rev 1.0
// ================================================================
package ids_dma_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } dma_state_e;

    localparam logic [3:0]  REGION_BUF = 4'h2;
    localparam logic [3:0]  REGION_PIM = 4'h4;
    localparam logic [3:0]  SIZE_WORD  = 4'hF;
    localparam logic [31:0] ADDR_STEP  = 32'd4;

    // Region nibble is kept; only the low 28 bits advance and wrap.
    function automatic logic [31:0] addr_inc(input logic [31:0] a);
        return {a[31:28], a[27:0] + ADDR_STEP[27:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ids_dma_ctrl.sv
`default_nettype none
// ================================================================
// ids_dma_ctrl : single-channel buffer-SRAM -> Hybrid-PIM word DMA
// Build option : IDS_DMA_IRQ_EN enables the sticky interrupt flop
// Rev 1.0
// ================================================================
module ids_dma_ctrl
    import ids_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [31:0]      i_src_addr,
    input  logic [31:0]      i_dst_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_irq,
    output logic             o_req_dma,
    input  logic             i_gnt_dma,
    output logic [31:0]      o_dma_addr_0,
    output logic             o_dma_write_0,
    output logic             o_dma_read_0,
    output logic [3:0]       o_dma_size_0,
    output logic [31:0]      o_dma_din_0,
    input  logic [31:0]      i_dma_dout_0,
    output logic [31:0]      o_dma_addr_1,
    output logic             o_dma_write_1,
    output logic             o_dma_read_1,
    output logic [3:0]       o_dma_size_1,
    output logic [31:0]      o_dma_din_1,
    input  logic [31:0]      i_dma_dout_1
);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             w_rd0;
    logic             w_wr1;
    logic             w_desc_bad;
    logic             w_start_acc;
    logic             unused_dout1;

    assign unused_dout1 = ^i_dma_dout_1;

    assign w_desc_bad  = (i_src_addr[31:28] != REGION_BUF) ||
                         (i_dst_addr[31:28] != REGION_PIM) ||
                         (i_src_addr[1:0] != 2'b00) ||
                         (i_dst_addr[1:0] != 2'b00);
    assign w_start_acc = (state_q == S_IDLE) && i_start && !i_abort;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        first_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        w_rd0   = 1'b0;
        w_wr1   = 1'b0;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        src_d = i_src_addr;
                        dst_d = i_dst_addr;
                        cnt_d = i_len;
                        err_d = w_desc_bad;
                        if (!w_desc_bad) begin
                            if (i_len == '0) done_d  = 1'b1;
                            else             state_d = S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (i_gnt_dma) begin
                        w_rd0   = 1'b1;
                        first_d = 1'b1;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Return data is only valid the cycle after the read strobe.
                    if (first_q) data_d = i_dma_dout_0;
                    if (i_gnt_dma) begin
                        w_wr1 = 1'b1;
                        src_d = addr_inc(src_q);
                        dst_d = addr_inc(dst_q);
                        cnt_d = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            first_q <= first_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef IDS_DMA_IRQ_EN
    logic irq_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                               irq_q <= 1'b0;
        else if (done_d || (w_start_acc && w_desc_bad)) irq_q <= 1'b1;
        else if (w_start_acc)                       irq_q <= 1'b0;
    end
    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_req_dma     = o_busy;
    assign o_dma_addr_0  = o_busy ? src_q : 32'h0;
    assign o_dma_addr_1  = o_busy ? dst_q : 32'h0;
    assign o_dma_read_0  = w_rd0;
    assign o_dma_size_0  = w_rd0 ? SIZE_WORD : 4'h0;
    assign o_dma_write_0 = 1'b0;
    assign o_dma_din_0   = 32'h0;
    assign o_dma_write_1 = w_wr1;
    assign o_dma_size_1  = w_wr1 ? SIZE_WORD : 4'h0;
    assign o_dma_din_1   = w_wr1 ? (first_q ? i_dma_dout_0 : data_q) : 32'h0;
    assign o_dma_read_1  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ids_dma_ctrl.sv
`default_nettype none
// ================================================================
// tb_ids_dma_ctrl : randomized bench with an operation-count model
// Rev 1.0
// ================================================================
module tb_ids_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_src_addr = '0;
    logic [31:0] i_dst_addr = '0;
    logic [15:0] i_len = '0;
    logic        i_gnt_dma = 1'b0;
    logic [31:0] i_dma_dout_0 = '0;
    logic [31:0] i_dma_dout_1 = 32'hDEAD_BEEF;
    logic        o_busy, o_done, o_err, o_irq, o_req_dma;
    logic [31:0] o_dma_addr_0, o_dma_din_0, o_dma_addr_1, o_dma_din_1;
    logic        o_dma_write_0, o_dma_read_0, o_dma_write_1, o_dma_read_1;
    logic [3:0]  o_dma_size_0, o_dma_size_1;

    ids_dma_ctrl #(.LEN_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_irq(o_irq),
        .o_req_dma(o_req_dma), .i_gnt_dma(i_gnt_dma),
        .o_dma_addr_0(o_dma_addr_0), .o_dma_write_0(o_dma_write_0),
        .o_dma_read_0(o_dma_read_0), .o_dma_size_0(o_dma_size_0),
        .o_dma_din_0(o_dma_din_0), .i_dma_dout_0(i_dma_dout_0),
        .o_dma_addr_1(o_dma_addr_1), .o_dma_write_1(o_dma_write_1),
        .o_dma_read_1(o_dma_read_1), .o_dma_size_1(o_dma_size_1),
        .o_dma_din_1(o_dma_din_1), .i_dma_dout_1(i_dma_dout_1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] buf_word(input logic [31:0] a);
        return 32'hA0 + {6'd0, a[27:2]};
    endfunction

    function automatic logic [31:0] waddr(input logic [31:0] b, input int k);
        return {b[31:28], b[27:0] + 28'(k * 4)};
    endfunction

    // Buffer SRAM: data is valid only the cycle after a read strobe.
    always @(posedge clk)
        i_dma_dout_0 <= o_dma_read_0 ? buf_word(o_dma_addr_0) : $urandom;

    int total = 0;
    int bad = 0;
    int test_id = 0;
    int tmo_cnt = 0;
    int tmo_seen = 0;

    logic        m_busy = 0, m_done = 0, m_err = 0, m_irq = 0, n_done, bad_d;
    int          m_ops = 0, m_len = 0, s_edge = 0, rel, k, n_written = 0;
    logic [31:0] m_src = 0, m_dst = 0;
    int          wr_cyc[$];
    logic [31:0] rd_log[$];
    logic [31:0] pim[logic [31:0]];
    logic        exp_rd, exp_wr;
    int          T1_WR[4] = '{2, 4, 6, 8};
    int          T2_WR[4] = '{5, 7, 9, 11};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (tmo_cnt != tmo_seen) begin
            check("bounded wait", tmo_cnt, tmo_seen);
            tmo_seen = tmo_cnt;
        end
        if (!rst_n) begin
            check("rst busy", o_busy, 0);   check("rst done", o_done, 0);
            check("rst err", o_err, 0);     check("rst irq", o_irq, 0);
            check("rst req", o_req_dma, 0); check("rst rd0", o_dma_read_0, 0);
            check("rst wr1", o_dma_write_1, 0);
            check("rst addr0", o_dma_addr_0, 0); check("rst addr1", o_dma_addr_1, 0);
            m_busy = 0; m_done = 0; m_err = 0; m_irq = 0;
        end else begin
            rel = cyc - s_edge + 1;
            k   = m_ops / 2;
            exp_rd = m_busy && i_gnt_dma && !i_abort && (m_ops % 2 == 0);
            exp_wr = m_busy && i_gnt_dma && !i_abort && (m_ops % 2 == 1);
            check("busy", o_busy, m_busy);
            check("done", o_done, m_done);
            check("err", o_err, m_err);
            check("irq", o_irq, m_irq);
            check("req", o_req_dma, m_busy);
            check("addr0", o_dma_addr_0, m_busy ? waddr(m_src, k) : 32'h0);
            check("addr1", o_dma_addr_1, m_busy ? waddr(m_dst, k) : 32'h0);
            check("read0", o_dma_read_0, exp_rd);
            check("write1", o_dma_write_1, exp_wr);
            check("unused drives", {o_dma_write_0, o_dma_read_1, o_dma_din_0}, 0);
            if (exp_rd) begin
                check("size0", o_dma_size_0, 4'hF);
            end
            if (exp_wr) begin
                check("size1", o_dma_size_1, 4'hF);
                check("din1", o_dma_din_1, buf_word(waddr(m_src, k)));
            end
            if (o_dma_read_0) rd_log.push_back(o_dma_addr_0);
            if (o_dma_write_1) begin
                pim[o_dma_addr_1] = o_dma_din_1;
                wr_cyc.push_back(rel);
                n_written++;
            end

            if (test_id == 1 && m_done) begin
                check("t1 done cycle", rel, 9);
                check("t1 write count", wr_cyc.size(), 4);
                for (int i = 0; i < 4; i++) begin
                    if (i < wr_cyc.size()) check("t1 write cycle", wr_cyc[i], T1_WR[i]);
                    check("t1 pim word", pim[32'h4000_0010 + 32'(4 * i)], 32'hA0 + 32'(i));
                end
            end
            if (test_id == 2 && m_done) begin
                check("t2 done cycle", rel, 12);
                check("t2 write count", wr_cyc.size(), 4);
                for (int i = 0; i < 4; i++) begin
                    if (i < wr_cyc.size()) check("t2 write cycle", wr_cyc[i], T2_WR[i]);
                    check("t2 pim word", pim[32'h4000_0010 + 32'(4 * i)], 32'hA0 + 32'(i));
                end
            end
            if (test_id == 3 && rel == 1) begin
                check("t3 err", o_err, 1);
                check("t3 req", o_req_dma, 0);
`ifdef IDS_DMA_IRQ_EN
                check("t3 irq", o_irq, 1);
`else
                check("t3 irq", o_irq, 0);
`endif
            end
            if (test_id == 4 && rel == 1) begin
                check("t4 done", o_done, 1);
                check("t4 busy", o_busy, 0);
                check("t4 req", o_req_dma, 0);
            end
            if (test_id == 5 && m_done) begin
                check("t5 reads", rd_log.size(), 2);
                if (rd_log.size() == 2) check("t5 wrap addr", rd_log[1], 32'h2000_0000);
            end
            if (test_id == 6 && (rel == 4 || rel == 5)) begin
                check("t6 busy", o_busy, 0);
                check("t6 done", o_done, 0);
                check("t6 err", o_err, 0);
                check("t6 words", n_written, 1);
            end

            n_done = 0;
            if (i_abort) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (i_start) begin
                    bad_d = (i_src_addr[31:28] != 4'h2) || (i_dst_addr[31:28] != 4'h4) ||
                            (i_src_addr[1:0] != 0) || (i_dst_addr[1:0] != 0);
                    m_err = bad_d;
                    s_edge = cyc + 1;
                    wr_cyc.delete(); rd_log.delete(); pim.delete(); n_written = 0;
`ifdef IDS_DMA_IRQ_EN
                    m_irq = bad_d || (i_len == 0);
`endif
                    if (!bad_d) begin
                        if (i_len == 0) n_done = 1;
                        else begin
                            m_busy = 1; m_ops = 0; m_len = int'(i_len);
                            m_src = i_src_addr; m_dst = i_dst_addr;
                        end
                    end
                end
            end else if (i_gnt_dma) begin
                m_ops++;
                if (m_ops == 2 * m_len) begin
                    m_busy = 0;
                    n_done = 1;
`ifdef IDS_DMA_IRQ_EN
                    m_irq = 1;
`endif
                end
            end
            m_done = n_done;
        end
    end

    logic gnt_rand = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        i_start = 0;
        i_abort = 0;
        if (gnt_rand) i_gnt_dma = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int n);
        i_start = 1; i_src_addr = s; i_dst_addr = d; i_len = 16'(n);
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) tmo_cnt++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, d;
        int sel, n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick(); tick();

        test_id = 1; i_gnt_dma = 1;
        start_xfer(32'h2000_0000, 32'h4000_0010, 4);
        wait_idle(); tick(); tick();

        test_id = 2;
        start_xfer(32'h2000_0000, 32'h4000_0010, 4);
        tick(); i_gnt_dma = 0;
        tick(); i_gnt_dma = 0;
        tick(); i_gnt_dma = 0;
        tick(); i_gnt_dma = 1;
        wait_idle(); tick(); tick();

        test_id = 3;
        start_xfer(32'h2000_0000, 32'h8000_0000, 3);
        tick(); tick(); tick();

        test_id = 4;
        start_xfer(32'h2000_0040, 32'h4000_0040, 0);
        tick(); tick();

        test_id = 5;
        start_xfer(32'h2FFF_FFFC, 32'h4000_0100, 2);
        wait_idle(); tick(); tick();

        test_id = 6;
        start_xfer(32'h2000_0000, 32'h4000_0000, 4);
        tick();
        i_start = 1; i_src_addr = 32'h9000_0000; i_dst_addr = 32'h4000_0000; i_len = 16'd2;
        tick();
        i_abort = 1;
        tick(); tick(); tick();

        test_id = 7;
        i_start = 1; i_abort = 1; i_src_addr = 32'h3000_0000; i_len = 16'd1;
        tick(); tick();

        test_id = 0; gnt_rand = 1;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            s = {4'h2, 28'($urandom) & 28'h000_0FFC};
            d = {4'h4, 28'($urandom) & 28'h000_0FFC};
            if ($urandom_range(0, 4) == 0) s = {4'h2, 28'hFFF_FFF0};
            if ($urandom_range(0, 4) == 0) d = {4'h4, 28'hFFF_FFF4};
            n = $urandom_range(1, 6);
            if (sel == 0) s[31:28] = 4'h3;
            if (sel == 1) d[1] = 1'b1;
            if (sel == 2) n = 0;
            start_xfer(s, d, n);
            for (int c = 0; c < 300; c++) begin
                if (!o_busy) break;
                if ($urandom_range(0, 49) == 0) i_abort = 1;
                if ($urandom_range(0, 7) == 0) begin
                    i_start = 1; i_src_addr = $urandom; i_len = 16'($urandom_range(0, 3));
                end
                tick();
                if (c == 299) tmo_cnt++;
            end
            tick(); tick();
        end

        gnt_rand = 0;
        tick(); tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
